// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit drain.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;
  localparam int UART_DATA_BITS       = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } uart_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic bit_done
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_done = !clr && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_drain.sv
// Pulls bytes from a single-entry upstream register and serialises them as 8N1
// (or 8E1 when UART_TX_PARITY_EN is defined) frames on tx.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      has_data,
  output logic                      rd,
  input  logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      tx,
  output logic                      busy
);
  localparam int             IW       = $clog2(UART_DATA_BITS);
  localparam logic [IW-1:0]  LAST_BIT = IW'(UART_DATA_BITS - 1);

  uart_state_e               state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [IW-1:0]             bit_idx_q;
  logic                      tx_q, rd_q;
  logic                      baud_clr, bit_done;
`ifdef UART_TX_PARITY_EN
  logic                      par_q;
`endif

  // Counter only runs while a bit is on the line, so every bit starts from zero.
  assign baud_clr = (state_q == S_IDLE) || (state_q == S_READ) || (state_q == S_LOAD);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rd_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (has_data) begin
          rd_q    <= 1'b1;
          state_q <= S_READ;
        end
        S_READ: state_q <= S_LOAD;
        S_LOAD: begin
          shift_q <= rd_data;
          tx_q    <= 1'b0;
          state_q <= S_START;
`ifdef UART_TX_PARITY_EN
          par_q   <= ^rd_data;
`endif
        end
        S_START: if (bit_done) begin
          tx_q      <= shift_q[0];
          shift_q   <= shift_q >> 1;
          bit_idx_q <= '0;
          state_q   <= S_DATA;
        end
        S_DATA: if (bit_done) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_q    <= par_q;
            state_q <= S_PARITY;
`else
            tx_q    <= 1'b1;
            state_q <= S_STOP;
`endif
          end else begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + IW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (bit_done) begin
          tx_q    <= 1'b1;
          state_q <= S_STOP;
        end
`endif
        S_STOP: if (bit_done) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign rd   = rd_q;
  assign busy = (state_q != S_IDLE);
endmodule
